// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/issue controller sequencing ALU, external unit, program flow and DMA bus yield
module cpu_sequencer #(
    parameter int ROM_AW = 12,
    parameter int IW = 12
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [ROM_AW-1:0] ROM_Addr,
    input  logic [IW-1:0]     ROM_Data,
    output logic [5:0]        ALU_Op,
    output logic              ALU_Valid,
    input  logic              ALU_Ready,
    input  logic              ALU_Zero,
    output logic [IW-1:0]     Ext_Instr,
    output logic              Ext_Valid,
    input  logic              Ext_Ready,
    input  logic              DMA_Req,
    output logic              DMA_Ack,
    output logic              Halt
);
    typedef enum logic [2:0] {FETCH, DECODE, ALU, JMP, EXT, DMA, HALT} state_t;
    state_t state, state_n;
    logic [ROM_AW-1:0] pc, pc_n;
    logic [IW-1:0] ir, ir_n;
    logic halted, halted_n;
    logic [5:0] op;
    logic [1:0] kind;
    assign op = ir[5:0];
    assign kind = ir[7:6];
    assign ROM_Addr = pc;
    assign ALU_Op = op;
    assign Ext_Instr = ir;
    assign ALU_Valid = state == ALU;
    assign Ext_Valid = state == EXT;
    assign DMA_Ack = state == DMA;
    assign Halt = state == HALT;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= FETCH;
            pc <= '0;
            ir <= '0;
            halted <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            ir <= ir_n;
            halted <= halted_n;
        end
    end
    always_comb begin
        state_n = state;
        pc_n = pc;
        ir_n = ir;
        halted_n = halted;
        case (state)
            FETCH: begin
                if (DMA_Req) begin
                    state_n = DMA;
                end else begin
                    ir_n = ROM_Data;
                    pc_n = pc + 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                state_n = kind == 2'b00 ? ALU : kind == 2'b01 ? (op == 6'h3f ? HALT : JMP) : EXT;
                if (kind == 2'b01 && op == 6'h3f) halted_n = 1'b1;
            end
            ALU: state_n = ALU_Ready ? FETCH : ALU;
            JMP: begin
                pc_n = (op == 6'h00 || (op == 6'h01 && ALU_Zero)) ? ROM_AW'(ROM_Data) : pc + 1'b1;
                state_n = FETCH;
            end
            EXT: state_n = Ext_Ready ? FETCH : EXT;
            DMA: state_n = DMA_Req ? DMA : halted ? HALT : FETCH;
            HALT: state_n = DMA_Req ? DMA : HALT;
            default: state_n = FETCH;
        endcase
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction fetch/decode/issue controller for the microcontroller core. Fetches 12-bit words from program ROM, decodes the instruction type and sequences the ALU, the external execution unit (load/store/send) and program-flow changes. Yields the bus to the DMA engine only at instruction boundaries. Sits between program ROM and the ALU/bus datapath inside the top-level.

## Interface
- ROM_AW, 12, program ROM address width; PC width
- IW, 12, instruction/ROM word width

- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- ROM_Addr  out  ROM_AW  program ROM address; always equals PC
- ROM_Data  in  IW  ROM word; combinational from ROM_Addr, valid in the same cycle
- ALU_Op  out  6  ALU opcode (IR[5:0])
- ALU_Valid  out  1  ALU command request
- ALU_Ready  in  1  ALU accepts/completes current command
- ALU_Zero  in  1  ALU zero flag, sampled during conditional jump
- Ext_Instr  out  IW  instruction word for external unit (IR)
- Ext_Valid  out  1  external-unit command request
- Ext_Ready  in  1  external unit accepts/completes command
- DMA_Req  in  1  DMA requests the bus
- DMA_Ack  out  1  bus granted to DMA
- Halt  out  1  core halted

## Operation
- Decode: IR[7:6] = type, IR[5:0] = op; IR[11:8] ignored. Type 00 = ALU (TYPE_1), 01 = flow control, 10/11 = external unit.
- Flow ops: 000000 JMP (unconditional), 000001 JMP_COND (taken if ALU_Zero=1), 111111 HALT; any other flow op = NOP that still skips the operand word. Jump target is the next ROM word (12 bits).
- States: FETCH, DECODE, ALU, JMP, EXT, DMA, HALT.
- FETCH: if DMA_Req=1 -> DMA (no fetch, PC unchanged). Else IR<=ROM_Data, PC<=PC+1, -> DECODE.
- DECODE: type 00 -> ALU; type 01 with op 111111 -> HALT; other type 01 -> JMP; type 10/11 -> EXT.
- ALU: ALU_Valid=1, ALU_Op=IR[5:0]; stay until ALU_Ready=1, then -> FETCH.
- JMP: ROM_Addr=PC points at operand; if op=JMP, or op=JMP_COND and ALU_Zero=1: PC<=ROM_Data; else PC<=PC+1; -> FETCH.
- EXT: Ext_Valid=1, Ext_Instr=IR; stay until Ext_Ready=1, then -> FETCH.
- DMA: DMA_Ack=1; leave when DMA_Req=0 sampled: -> HALT if halted flag set, else -> FETCH.
- HALT: Halt=1; DMA_Req=1 -> DMA (halted flag set); otherwise stays until Rst.
- PC arithmetic modulo 2^ROM_AW: 4095+1 -> 0; jump at 4094 takes its operand from 4095; jump at 4095 takes operand from 0.
- DMA never interrupts ALU/EXT/JMP; a request during them waits until next FETCH.

## Timing
- Reset (Rst=1 at a rising edge): state FETCH, PC=0, IR=0, halted flag=0; ROM_Addr=0, ALU_Op=0, ALU_Valid=0, Ext_Instr=0, Ext_Valid=0, DMA_Ack=0, Halt=0 from the next cycle. Rst overrides every state including mid-handshake; pending Valid drops immediately.
- All outputs Moore (decoded from state/IR/PC registers); no combinational input-to-output paths except none.
- ALU or EXT instruction: FETCH, DECODE, then >=1 cycle in ALU/EXT; minimum 3 cycles per instruction with Ready=1 in the first ALU/EXT cycle.
- Valid rises on the cycle after DECODE and stays high until the cycle in which Ready=1 is sampled; Valid low the following cycle. Ready while Valid=0 ignored.
- Jump: 3 cycles (FETCH, DECODE, JMP); new PC on ROM_Addr the cycle after JMP.
- DMA_Ack rises the cycle after DMA_Req is sampled in FETCH/HALT; falls the cycle after DMA_Req=0 is sampled; worst-case grant latency = remaining cycles of current instruction + 1.

## Test plan
- Reset then ROM[0..10] = TYPE_1 ALU_ADD..ALU_BIN2ASCII, ALU_Ready tied 1 -> ALU_Op sequence 0..10 opcodes, each Valid pulse 1 cycle, one instruction per 3 cycles, ROM_Addr 0..11.
- ALU_Ready delayed 4 cycles on ADD -> ALU_Valid held 5 cycles, ALU_Op stable, PC stays 1 until next FETCH.
- ROM[0]=JMP, ROM[1]=12'h100; ROM[0x100]=JMP_COND, ROM[0x101]=12'h020 with ALU_Zero=1 then repeated with ALU_Zero=0 -> PC 0x100 then 0x020; not-taken case PC 0x102.
- DMA_Req asserted mid-ALU-handshake for 6 cycles -> DMA_Ack only after ALU completes, high while Req high, fetch resumes at unchanged PC.
- HALT at 0x005 -> Halt=1, ROM_Addr=6 frozen; DMA_Req pulse -> DMA_Ack granted, returns to HALT; Rst -> PC=0, Halt=0.
- Jump at 4095 with ROM[0]=12'h010 -> operand read from address 0, PC=0x010; Rst asserted during EXT wait -> Ext_Valid=0 next cycle, fetch from 0.
